// File: rtl/phase_sched.sv
// Request-driven round-robin phase scheduler for the J/P/C crossing.
// Min/max green, yellow and all-red clearance on a prescaled tick.
module phase_sched #(
    parameter int TICK_DIV = 1000,
    parameter int MIN_G    = 5,
    parameter int MAX_G    = 10,
    parameter int YEL      = 3,
    parameter int ALLRED   = 1,
    parameter int CW       = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       adv,
    input  logic       hold,
    output logic [2:0] grn,
    output logic [2:0] yel,
    output logic [1:0] phase,
    output logic [2:0] pend
);

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_TOP = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_MIN = CW'(MIN_G);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_G);
    localparam logic [CW-1:0] C_YEL = CW'(YEL);
    localparam logic [CW-1:0] C_AR  = CW'(ALLRED);

    function automatic logic [2:0] onehot(input logic [1:0] p);
        case (p)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            default: onehot = 3'b100;
        endcase
    endfunction

    function automatic logic [1:0] nxt(input logic [1:0] p);
        nxt = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    state_t        state, state_n;
    logic [1:0]    phase_n, p1, p2, win;
    logic [CW-1:0] sec, sec_n, pre, pre_n, n;
    logic [2:0]    pend_n, grn_n, yel_n, mask;
    logic          tick, other, own, enter_g;

    always_comb begin
        state_n = state;
        phase_n = phase;
        sec_n   = sec;
        enter_g = 1'b0;
        tick    = !hold && (pre == C_TOP);
        n       = sec + CW'(1);
        p1      = nxt(phase);
        p2      = nxt(p1);
        other   = |(pend & ~onehot(phase));
        own     = |(req & onehot(phase));

        // Round-robin search starting after the current owner; J rests
        if (|(pend & onehot(p1)))         win = p1;
        else if (|(pend & onehot(p2)))    win = p2;
        else if (|(pend & onehot(phase))) win = phase;
        else                              win = 2'd0;

        if (tick) sec_n = n;

        unique case (state)
            S_ALLRED: begin
                if (tick && n >= C_AR) begin
                    state_n = S_GREEN;
                    phase_n = win;
                    enter_g = 1'b1;
                end
            end
            S_GREEN: begin
                if (tick && n >= C_MAX) sec_n = C_MAX;
                if (adv && other)
                    state_n = S_YELLOW;
                else if (tick && other && n >= C_MIN &&
                         (!own || n >= C_MAX))
                    state_n = S_YELLOW;
            end
            S_YELLOW: begin
                if (tick && n >= C_YEL) state_n = S_ALLRED;
            end
            default: state_n = S_ALLRED;
        endcase

        if (state_n != state) begin
            sec_n = '0;
            pre_n = '0;
        end else if (hold) begin
            pre_n = pre;
        end else if (tick) begin
            pre_n = '0;
        end else begin
            pre_n = pre + CW'(1);
        end

        // The green owner's own request is served by extension, not latched
        mask   = (state == S_GREEN) ? ~onehot(phase) : 3'b111;
        pend_n = pend | (req & mask);
        if (enter_g) pend_n = pend_n & ~onehot(phase_n);

        grn_n = (state_n == S_GREEN)  ? onehot(phase_n) : 3'b000;
        yel_n = (state_n == S_YELLOW) ? onehot(phase_n) : 3'b000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_ALLRED;
            phase <= 2'd2;
            sec   <= '0;
            pre   <= '0;
            pend  <= 3'b000;
            grn   <= 3'b000;
            yel   <= 3'b000;
        end else begin
            state <= state_n;
            phase <= phase_n;
            sec   <= sec_n;
            pre   <= pre_n;
            pend  <= pend_n;
            grn   <= grn_n;
            yel   <= yel_n;
        end
    end

endmodule

// File: tb/tb_phase_sched.sv
// Directed bench for phase_sched with a 4-cycle tick, MIN_G=2, MAX_G=4.
// Edge numbers count rising clk edges after reset release.
module tb_phase_sched;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       adv;
    logic       hold;
    logic [2:0] grn;
    logic [2:0] yel;
    logic [1:0] phase;
    logic [2:0] pend;

    int checks;
    int errors;
    int ec;

    phase_sched #(
        .TICK_DIV(4),
        .MIN_G(2),
        .MAX_G(4),
        .YEL(1),
        .ALLRED(1),
        .CW(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .adv(adv),
        .hold(hold),
        .grn(grn),
        .yel(yel),
        .phase(phase),
        .pend(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic goto(input int e);
        while (ec < e) cyc();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        req  = 3'b000;
        adv  = 1'b0;
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ec  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grn !== 3'b000 || yel !== 3'b000 || pend !== 3'b000 ||
            phase !== 2'd2) begin
            errors++;
            $display("FAIL reset_state grn=%b yel=%b pend=%b phase=%0d exp 000/000/000/2",
                     grn, yel, pend, phase);
        end
        for (int i = 1; i <= 3; i++) begin
            cyc();
            checks++;
            if (grn !== 3'b000 || yel !== 3'b000) begin
                errors++;
                $display("FAIL reset_allred_e%0d grn=%b yel=%b exp 000/000",
                         ec, grn, yel);
            end
        end
        cyc();
        checks++;
        if (grn !== 3'b001 || phase !== 2'd0) begin
            errors++;
            $display("FAIL reset_j_green_e4 grn=%b phase=%0d exp 001/0",
                     grn, phase);
        end
        for (int i = 0; i < 44; i++) begin
            cyc();
            checks++;
            if (grn !== 3'b001 || yel !== 3'b000) begin
                errors++;
                $display("FAIL reset_j_rest_e%0d grn=%b yel=%b exp 001/000",
                         ec, grn, yel);
            end
        end
    endtask

    task automatic test_ped_request();
        do_reset();
        goto(14);
        req = 3'b010;
        cyc();
        req = 3'b000;
        checks++;
        if (pend !== 3'b010 || grn !== 3'b001) begin
            errors++;
            $display("FAIL ped_latch_e15 pend=%b grn=%b exp 010/001",
                     pend, grn);
        end
        cyc();
        checks++;
        if (yel !== 3'b001 || grn !== 3'b000) begin
            errors++;
            $display("FAIL ped_yel_e16 yel=%b grn=%b exp 001/000", yel, grn);
        end
        goto(19);
        checks++;
        if (yel !== 3'b001) begin
            errors++;
            $display("FAIL ped_yel_hold_e19 yel=%b exp 001", yel);
        end
        cyc();
        checks++;
        if (yel !== 3'b000 || grn !== 3'b000) begin
            errors++;
            $display("FAIL ped_allred_e20 yel=%b grn=%b exp 000/000", yel, grn);
        end
        goto(24);
        checks++;
        if (grn !== 3'b010 || pend !== 3'b000 || phase !== 2'd1) begin
            errors++;
            $display("FAIL ped_green_e24 grn=%b pend=%b phase=%0d exp 010/000/1",
                     grn, pend, phase);
        end
    endtask

    task automatic test_max_green();
        // C request held high: green extends to MAX_G
        do_reset();
        goto(4);
        req = 3'b100;
        goto(20);
        checks++;
        if (grn !== 3'b100 || phase !== 2'd2 || pend !== 3'b000) begin
            errors++;
            $display("FAIL max_c_green_e20 grn=%b phase=%0d pend=%b exp 100/2/000",
                     grn, phase, pend);
        end
        req = 3'b101;
        cyc();
        req = 3'b100;
        checks++;
        if (pend !== 3'b001) begin
            errors++;
            $display("FAIL max_pend_e21 pend=%b exp 001", pend);
        end
        goto(35);
        checks++;
        if (grn !== 3'b100 || yel !== 3'b000) begin
            errors++;
            $display("FAIL max_still_green_e35 grn=%b yel=%b exp 100/000",
                     grn, yel);
        end
        cyc();
        checks++;
        if (yel !== 3'b100 || grn !== 3'b000) begin
            errors++;
            $display("FAIL max_yel_e36 yel=%b grn=%b exp 100/000", yel, grn);
        end
        req = 3'b000;
        // C request dropped: green ends at MIN_G
        do_reset();
        goto(4);
        req = 3'b100;
        cyc();
        req = 3'b000;
        goto(20);
        req = 3'b001;
        cyc();
        req = 3'b000;
        goto(27);
        checks++;
        if (grn !== 3'b100) begin
            errors++;
            $display("FAIL min_still_green_e27 grn=%b exp 100", grn);
        end
        cyc();
        checks++;
        if (yel !== 3'b100 || grn !== 3'b000) begin
            errors++;
            $display("FAIL min_yel_e28 yel=%b grn=%b exp 100/000", yel, grn);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        goto(4);
        req = 3'b110;
        cyc();
        req = 3'b000;
        checks++;
        if (pend !== 3'b110) begin
            errors++;
            $display("FAIL rr_pend_e5 pend=%b exp 110", pend);
        end
        goto(12);
        checks++;
        if (yel !== 3'b001) begin
            errors++;
            $display("FAIL rr_j_yel_e12 yel=%b exp 001", yel);
        end
        goto(20);
        checks++;
        if (phase !== 2'd1 || grn !== 3'b010 || pend !== 3'b100) begin
            errors++;
            $display("FAIL rr_p_e20 phase=%0d grn=%b pend=%b exp 1/010/100",
                     phase, grn, pend);
        end
        goto(36);
        checks++;
        if (phase !== 2'd2 || grn !== 3'b100 || pend !== 3'b000) begin
            errors++;
            $display("FAIL rr_c_e36 phase=%0d grn=%b pend=%b exp 2/100/000",
                     phase, grn, pend);
        end
        req = 3'b001;
        cyc();
        req = 3'b000;
        goto(52);
        checks++;
        if (phase !== 2'd0 || grn !== 3'b001) begin
            errors++;
            $display("FAIL rr_j_e52 phase=%0d grn=%b exp 0/001", phase, grn);
        end
    endtask

    task automatic test_manual_adv();
        do_reset();
        goto(4);
        req = 3'b100;
        cyc();
        req = 3'b000;
        adv = 1'b1;
        checks++;
        if (grn !== 3'b001 || pend !== 3'b100) begin
            errors++;
            $display("FAIL adv_pre_e5 grn=%b pend=%b exp 001/100", grn, pend);
        end
        cyc();
        adv = 1'b0;
        checks++;
        if (yel !== 3'b001 || grn !== 3'b000) begin
            errors++;
            $display("FAIL adv_yel_e6 yel=%b grn=%b exp 001/000", yel, grn);
        end
        do_reset();
        goto(5);
        adv = 1'b1;
        cyc();
        adv = 1'b0;
        checks++;
        if (grn !== 3'b001 || yel !== 3'b000 || pend !== 3'b000) begin
            errors++;
            $display("FAIL adv_ignored_e6 grn=%b yel=%b pend=%b exp 001/000/000",
                     grn, yel, pend);
        end
        goto(12);
        checks++;
        if (grn !== 3'b001 || yel !== 3'b000) begin
            errors++;
            $display("FAIL adv_rest_e12 grn=%b yel=%b exp 001/000", grn, yel);
        end
    endtask

    task automatic test_hold_reset();
        do_reset();
        goto(4);
        req = 3'b010;
        cyc();
        req = 3'b000;
        goto(13);
        checks++;
        if (yel !== 3'b001) begin
            errors++;
            $display("FAIL hold_yel_e13 yel=%b exp 001", yel);
        end
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (yel !== 3'b001 || grn !== 3'b000) begin
                errors++;
                $display("FAIL hold_frozen_e%0d yel=%b grn=%b exp 001/000",
                         ec, yel, grn);
            end
        end
        hold = 1'b0;
        goto(35);
        checks++;
        if (yel !== 3'b001) begin
            errors++;
            $display("FAIL hold_yel_e35 yel=%b exp 001", yel);
        end
        cyc();
        checks++;
        if (yel !== 3'b000 || grn !== 3'b000) begin
            errors++;
            $display("FAIL hold_exit_e36 yel=%b grn=%b exp 000/000", yel, grn);
        end
        goto(40);
        checks++;
        if (grn !== 3'b010) begin
            errors++;
            $display("FAIL hold_p_green_e40 grn=%b exp 010", grn);
        end
        req = 3'b001;
        cyc();
        req = 3'b000;
        cyc();
        checks++;
        if (pend !== 3'b001 || grn !== 3'b010) begin
            errors++;
            $display("FAIL async_pre pend=%b grn=%b exp 001/010", pend, grn);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (grn !== 3'b000 || yel !== 3'b000 || pend !== 3'b000 ||
            phase !== 2'd2) begin
            errors++;
            $display("FAIL async_reset grn=%b yel=%b pend=%b phase=%0d exp 000/000/000/2",
                     grn, yel, pend, phase);
        end
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ec     = 0;
        rst    = 1'b0;
        req    = 3'b000;
        adv    = 1'b0;
        hold   = 1'b0;
        test_reset();
        test_ped_request();
        test_max_green();
        test_round_robin();
        test_manual_adv();
        test_hold_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_sched.md
Name: phase_sched

Overview:
- Round-robin phase scheduler for the three-way signalised crossing: J and C are the two vehicle approaches, P is the pedestrian phase.
- Replaces fixed-cycle sequencing with request-driven sequencing, and adds a minimum green, a maximum green, a yellow clearance and an all-red clearance.
- Sits between the sensor/push-button inputs and the lamp drivers.
- Derives its 1 s timebase from the system clock using an internal prescaler.

Parameters:
- TICK_DIV, 1000: clk cycles per timing tick; 1 tick = 1 s at a 1 kHz clk.
- MIN_G, 5: minimum green duration, in ticks.
- MAX_G, 10: maximum green extension while the current phase's own request stays high, in ticks.
- YEL, 3: yellow clearance duration, in ticks.
- ALLRED, 1: all-red clearance duration, in ticks.
- CW, 12: width of the tick and prescaler counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- req  input  3  request lines. bit0=J, bit1=P, bit2=C. Level or pulse; one clk cycle is sufficient to register.
- adv  input  1  manual advance pulse.
- hold  input  1  freezes all timing while high.
- grn  output  3  one-hot green lamp, bit order as req.
- yel  output  3  one-hot yellow lamp, bit order as req.
- phase  output  2  current owner: 0=J, 1=P, 2=C.
- pend  output  3  latched pending requests.

Behaviour:
- Reset (rst=0, asynchronous, effective at any time including mid-phase):
  - grn=000, yel=000, pend=000, phase=2.
  - State=ALLRED; tick counter=0; prescaler=0.
- Prescaler:
  - Counts 0..TICK_DIV-1. tick=1 for exactly the one cycle where the count is TICK_DIV-1.
  - Cleared on every state change, so each state lasts an exact multiple of TICK_DIV cycles.
  - hold=1 freezes the prescaler and the tick counter. Outputs and request latching remain active during hold.
- Pending latch:
  - pend[i] is set on any clk edge where req[i]=1.
  - Exception: req[phase] is not latched while in GREEN.
  - pend[i] is cleared on the edge that enters GREEN for phase i. Clear wins over a same-edge set for that bit.
- States:
  - ALLRED: grn=000, yel=000.
    - Advances on the edge where tick=1 and sec+1==ALLRED.
    - Arbitration on exit: search phase+1, phase+2, phase (mod 3); the first set pend bit wins.
    - If pend=000, J wins as the rest phase.
    - Enter GREEN with phase=winner.
  - GREEN: grn=one-hot(phase), yel=000.
    - other = OR of pend bits excluding phase.
    - On a tick edge, with n=sec+1:
      - Exit to YELLOW if other=1 and n>=MIN_G and (req[phase]=0 or n>=MAX_G).
      - Otherwise sec=n, saturating at MAX_G.
    - Rest: if other=0, the phase remains green indefinitely.
    - Manual advance: adv=1 with other=1 forces YELLOW on that same edge, regardless of MIN_G.
    - adv=1 with other=0 is ignored.
  - YELLOW: grn=000, yel=one-hot(phase). Exits to ALLRED on the tick edge where sec+1==YEL.
- Timing rules:
  - sec is cleared on every state entry.
  - All outputs are registered; lamp changes appear on the transition edge.
  - grn and yel are never both non-zero.
  - At most one bit of grn|yel is ever set.
- Reset wins over every other input.
- Widths:
  - MIN_G<=MAX_G<2^CW is required.
  - YEL>=1 and ALLRED>=1 are required.
  - The sec counter never wraps.

Test Plan:
Common bench parameters: TICK_DIV=4, MIN_G=2, MAX_G=4, YEL=1, ALLRED=1. "Edge N" counts clk rising edges after rst release.
1. Reset release with req=000 -> grn=000 through edge 3; grn=001, phase=0 at edge 4; J then rests green for 40+ cycles with yel=000.
2. J resting green ≥2 ticks, single-cycle pulse req=010 -> pend=010; yel=001 at the next tick edge; grn=000/yel=000 4 cycles later; grn=010, pend=000 4 cycles after that.
3. Green C entered, req[2] held high, pend=001 -> C stays green for exactly 4 ticks (16 cycles, MAX_G), then yel=100; with req[2] low instead, C exits after 2 ticks (8 cycles).
4. pend=110 while J goes yellow -> the ALLRED exit grants P (phase=1) first, then C, then J again; check round-robin order 0→1→2→0.
5. J green 1 cycle after entry, pend=100, adv pulse -> yel=001 on the same edge; adv with pend=000 -> no change.
6. hold=1 for 20 cycles mid-YELLOW -> yel stays asserted, and the exit is delayed by exactly 20 cycles; rst=0 mid-GREEN -> grn=000, pend=000 immediately, with no clk edge needed.
